// File: rtl/fetch_byte_queue.sv
// Instruction fetch byte queue: issues aligned 8-byte reads, packs returned bytes into a 32-entry
// circular buffer and presents a 15-byte decode window starting at current_addr.
module fetch_byte_queue (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_addr,
    output logic         fetch_req,
    output logic [63:0]  fetch_addr,
    input  logic         fetch_gnt,
    input  logic         resp_valid,
    input  logic [63:0]  resp_data,
    output logic [119:0] buffer,
    output logic [63:0]  current_addr,
    output logic         win_valid,
    input  logic         consume,
    input  logic [3:0]   byte_incr,
    output logic [5:0]   occupancy
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

    state_e      state_q, state_d;
    logic [7:0]  mem_q [32];
    logic [7:0]  mem_d [32];
    logic [4:0]  head_q, head_d;
    logic [4:0]  tail_q, tail_d;
    logic [5:0]  occ_q, occ_d;
    logic [63:0] cur_q, cur_d;
    logic [63:0] fptr_q, fptr_d;
    logic [2:0]  skip_q, skip_d;

    logic        req_fire;
    logic        do_write;
    logic        do_consume;
    logic [3:0]  wr_cnt;

    // A request is only raised when a full word is guaranteed to fit on return.
    assign fetch_req    = (state_q == StReq) && (occ_q <= 6'd24);
    assign fetch_addr   = fptr_q;
    assign req_fire     = fetch_req && fetch_gnt;
    assign win_valid    = (occ_q >= 6'd15);
    assign do_write     = (state_q == StWait) && resp_valid;
    assign do_consume   = consume && win_valid && (byte_incr != 4'd0);
    assign wr_cnt       = 4'd8 - {1'b0, skip_q};
    assign occupancy    = occ_q;
    assign current_addr = cur_q;

    always_comb begin
        buffer = '0;
        for (int i = 0; i < 15; i++) begin
            buffer[8*i +: 8] = mem_q[head_q + 5'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        cur_d   = cur_q;
        fptr_d  = fptr_q;
        skip_d  = skip_q;

        case (state_q)
            StIdle: state_d = StIdle;
            StReq: begin
                if (req_fire) begin
                    state_d = StWait;
                    fptr_d  = fptr_q + 64'd8;
                end
            end
            StWait:  if (resp_valid) state_d = StReq;
            StDrain: if (resp_valid) state_d = StReq;
            default: state_d = StIdle;
        endcase

        if (do_write) begin
            for (int k = 0; k < 8; k++) begin
                if (3'(k) >= skip_q) begin
                    mem_d[tail_q + 5'(k) - 5'(skip_q)] = resp_data[8*k +: 8];
                end
            end
            tail_d = tail_q + 5'(wr_cnt);
            skip_d = 3'd0;
        end

        if (do_consume) begin
            head_d = head_q + 5'(byte_incr);
            cur_d  = cur_q + 64'(byte_incr);
        end

        occ_d = occ_q + (do_write ? 6'(wr_cnt) : 6'd0) - (do_consume ? 6'(byte_incr) : 6'd0);

        // Redirect flushes everything; an in-flight response must be swallowed in StDrain.
        if (redirect_valid) begin
            head_d  = 5'd0;
            tail_d  = 5'd0;
            occ_d   = 6'd0;
            cur_d   = redirect_addr;
            fptr_d  = {redirect_addr[63:3], 3'b000};
            skip_d  = redirect_addr[2:0];
            state_d = (state_q == StWait || state_q == StDrain || req_fire) ? StDrain : StReq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            head_q  <= 5'd0;
            tail_q  <= 5'd0;
            occ_q   <= 6'd0;
            cur_q   <= 64'd0;
            fptr_q  <= 64'd0;
            skip_q  <= 3'd0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            cur_q   <= cur_d;
            fptr_q  <= fptr_d;
            skip_q  <= skip_d;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue; memory data byte at address A is A[7:0], so the
// expected window is derived from the expected current_addr.
module tb_fetch_byte_queue;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_addr = '0;
    logic         fetch_req;
    logic [63:0]  fetch_addr;
    logic         fetch_gnt = 1'b0;
    logic         resp_valid = 1'b0;
    logic [63:0]  resp_data = '0;
    logic [119:0] buffer;
    logic [63:0]  current_addr;
    logic         win_valid;
    logic         consume = 1'b0;
    logic [3:0]   byte_incr = '0;
    logic [5:0]   occupancy;

    int total = 0;
    int bad = 0;

    fetch_byte_queue dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_gnt     (fetch_gnt),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .buffer        (buffer),
        .current_addr  (current_addr),
        .win_valid     (win_valid),
        .consume       (consume),
        .byte_incr     (byte_incr),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] raddr;
        logic        gnt;
        logic        rsp;
        logic [63:0] rdata;
        logic        con;
        logic [3:0]  incr;
        logic        e_req;
        logic [63:0] e_addr;
        logic [5:0]  e_occ;
        logic        e_win;
        logic [63:0] e_cur;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] pat(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = 8'(a + 64'(k));
        end
        return r;
    endfunction

    function automatic void v(input logic rst, input logic rv, input logic [63:0] raddr,
                              input logic gnt, input logic rsp, input logic [63:0] rdaddr,
                              input logic con, input logic [3:0] incr, input logic e_req,
                              input logic [63:0] e_addr, input logic [5:0] e_occ,
                              input logic e_win, input logic [63:0] e_cur);
        vec_t t;
        t.rst = rst;     t.rv = rv;         t.raddr = raddr;
        t.gnt = gnt;     t.rsp = rsp;       t.rdata = pat(rdaddr);
        t.con = con;     t.incr = incr;     t.e_req = e_req;
        t.e_addr = e_addr; t.e_occ = e_occ; t.e_win = e_win; t.e_cur = e_cur;
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; fetch_gnt = 1'b0;
        resp_valid = 1'b0; resp_data = '0; consume = 1'b0; byte_incr = '0;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!fetch_req && n < 10) begin
            tick();
            n++;
        end
        check(nm, 128'(fetch_req), 128'd1);
    endtask

    localparam logic [63:0] TopW = 64'hFFFF_FFFF_FFFF_FFF8;

    initial begin
        //  rst rv raddr      gnt rsp rdaddr    con incr req addr       occ win cur
        v(1, 0, 0,           0, 0, 0,          0, 0,  0, 0,          0,  0, 0);
        v(0, 0, 0,           0, 1, 0,          0, 0,  0, 0,          0,  0, 0);
        v(0, 1, 'h1000,      0, 0, 0,          0, 0,  1, 'h1000,     0,  0, 'h1000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, 'h1000);
        v(0, 0, 0,           0, 1, 'h1000,     0, 0,  1, 'h1008,     8,  0, 'h1000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          8,  0, 'h1000);
        v(0, 0, 0,           0, 1, 'h1008,     0, 0,  1, 'h1010,     16, 1, 'h1000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          16, 1, 'h1000);
        v(0, 0, 0,           0, 1, 'h1010,     0, 0,  1, 'h1018,     24, 1, 'h1000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          24, 1, 'h1000);
        v(0, 0, 0,           0, 1, 'h1018,     0, 0,  0, 0,          32, 1, 'h1000);
        v(0, 0, 0,           1, 1, 'h1020,     0, 0,  0, 0,          32, 1, 'h1000);
        v(0, 0, 0,           0, 0, 0,          1, 15, 1, 'h1020,     17, 1, 'h100F);
        v(0, 0, 0,           0, 0, 0,          1, 15, 1, 'h1020,     2,  0, 'h101E);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          2,  0, 'h101E);
        v(0, 0, 0,           0, 1, 'h1020,     0, 0,  1, 'h1028,     10, 0, 'h101E);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          10, 0, 'h101E);
        v(0, 0, 0,           0, 1, 'h1028,     0, 0,  1, 'h1030,     18, 1, 'h101E);
        v(0, 0, 0,           1, 0, 0,          1, 1,  0, 0,          17, 1, 'h101F);
        v(0, 0, 0,           0, 1, 'h1030,     1, 15, 1, 'h1038,     10, 0, 'h102E);
        v(0, 1, 'h2005,      0, 0, 0,          0, 0,  1, 'h2000,     0,  0, 'h2005);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, 'h2005);
        v(0, 0, 0,           0, 1, 'h2000,     0, 0,  1, 'h2008,     3,  0, 'h2005);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          3,  0, 'h2005);
        v(0, 0, 0,           0, 1, 'h2008,     0, 0,  1, 'h2010,     11, 0, 'h2005);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          11, 0, 'h2005);
        v(0, 0, 0,           0, 1, 'h2010,     0, 0,  1, 'h2018,     19, 1, 'h2005);
        v(0, 1, 'h4000,      0, 0, 0,          0, 0,  1, 'h4000,     0,  0, 'h4000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, 'h4000);
        v(0, 0, 0,           0, 1, 'h4000,     0, 0,  1, 'h4008,     8,  0, 'h4000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          8,  0, 'h4000);
        v(0, 0, 0,           0, 1, 'h4008,     0, 0,  1, 'h4010,     16, 1, 'h4000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          16, 1, 'h4000);
        v(0, 0, 0,           0, 1, 'h4010,     1, 5,  1, 'h4018,     19, 1, 'h4005);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          19, 1, 'h4005);
        v(0, 1, 'h3000,      0, 0, 0,          0, 0,  0, 0,          0,  0, 'h3000);
        v(0, 0, 0,           0, 1, 'h4018,     0, 0,  1, 'h3000,     0,  0, 'h3000);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, 'h3000);
        v(0, 0, 0,           0, 1, 'h3000,     0, 0,  1, 'h3008,     8,  0, 'h3000);
        v(0, 1, 'h5003,      1, 0, 0,          0, 0,  0, 0,          0,  0, 'h5003);
        v(0, 1, 'h5003,      0, 0, 0,          0, 0,  0, 0,          0,  0, 'h5003);
        v(0, 0, 0,           0, 1, 'h3008,     0, 0,  1, 'h5000,     0,  0, 'h5003);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, 'h5003);
        v(0, 0, 0,           0, 1, 'h5000,     0, 0,  1, 'h5008,     5,  0, 'h5003);
        v(0, 0, 0,           0, 0, 0,          1, 3,  1, 'h5008,     5,  0, 'h5003);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          5,  0, 'h5003);
        v(0, 0, 0,           0, 1, 'h5008,     0, 0,  1, 'h5010,     13, 0, 'h5003);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          13, 0, 'h5003);
        v(0, 0, 0,           0, 1, 'h5010,     0, 0,  1, 'h5018,     21, 1, 'h5003);
        v(0, 0, 0,           0, 0, 0,          1, 0,  1, 'h5018,     21, 1, 'h5003);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          21, 1, 'h5003);
        v(1, 0, 0,           0, 0, 0,          0, 0,  0, 0,          0,  0, 0);
        v(0, 0, 0,           0, 1, 'h5018,     0, 0,  0, 0,          0,  0, 0);
        v(1, 1, 'h6000,      0, 0, 0,          0, 0,  0, 0,          0,  0, 0);
        v(0, 0, 0,           0, 0, 0,          0, 0,  0, 0,          0,  0, 0);
        v(0, 1, TopW,        0, 0, 0,          0, 0,  1, TopW,       0,  0, TopW);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          0,  0, TopW);
        v(0, 0, 0,           0, 1, TopW,       0, 0,  1, 'h0,        8,  0, TopW);
        v(0, 0, 0,           1, 0, 0,          0, 0,  0, 0,          8,  0, TopW);
        v(0, 0, 0,           0, 1, 'h0,        0, 0,  1, 'h8,        16, 1, TopW);
        v(0, 0, 0,           0, 0, 0,          1, 15, 1, 'h8,        1,  0, 'h7);

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_addr  = vecs[i].raddr;
            fetch_gnt      = vecs[i].gnt;
            resp_valid     = vecs[i].rsp;
            resp_data      = vecs[i].rdata;
            consume        = vecs[i].con;
            byte_incr      = vecs[i].incr;
            tick();
            check($sformatf("v%0d fetch_req", i), 128'(fetch_req), 128'(vecs[i].e_req));
            check($sformatf("v%0d occupancy", i), 128'(occupancy), 128'(vecs[i].e_occ));
            check($sformatf("v%0d win_valid", i), 128'(win_valid), 128'(vecs[i].e_win));
            check($sformatf("v%0d current_addr", i), 128'(current_addr), 128'(vecs[i].e_cur));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d fetch_addr", i), 128'(fetch_addr), 128'(vecs[i].e_addr));
            end
            if (vecs[i].rst) begin
                check($sformatf("v%0d buffer_rst", i), 128'(buffer), 128'd0);
            end
            for (int j = 0; j < 15; j++) begin
                if (j < int'(vecs[i].e_occ)) begin
                    check($sformatf("v%0d byte%0d", i, j), 128'(buffer[8*j +: 8]),
                          128'(8'(vecs[i].e_cur + 64'(j))));
                end
            end
        end
        clr();

        // Fill to 32 with bounded waits, then hold grant while stalled on a full queue.
        redirect_valid = 1'b1;
        redirect_addr  = 64'h7000;
        tick();
        clr();
        for (int n = 0; n < 4; n++) begin
            wait_req($sformatf("seq fill%0d req_seen", n));
            check($sformatf("seq fill%0d addr", n), 128'(fetch_addr), 128'(64'h7000 + 64'(8*n)));
            fetch_gnt = 1'b1;
            tick();
            clr();
            resp_valid = 1'b1;
            resp_data  = pat(64'h7000 + 64'(8*n));
            tick();
            clr();
        end
        check("seq full occ", 128'(occupancy), 128'd32);
        check("seq full byte0", 128'(buffer[7:0]), 128'h00);
        check("seq full byte14", 128'(buffer[119:112]), 128'h0E);
        for (int n = 0; n < 3; n++) begin
            fetch_gnt = 1'b1;
            tick();
            check($sformatf("seq stall%0d req", n), 128'(fetch_req), 128'd0);
            check($sformatf("seq stall%0d occ", n), 128'(occupancy), 128'd32);
        end
        clr();
        consume   = 1'b1;
        byte_incr = 4'd15;
        tick();
        clr();
        check("seq drain occ", 128'(occupancy), 128'd17);
        check("seq drain cur", 128'(current_addr), 128'h700F);
        check("seq drain req", 128'(fetch_req), 128'd1);
        check("seq drain addr", 128'(fetch_addr), 128'h7020);
        check("seq drain byte0", 128'(buffer[7:0]), 128'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_byte_queue.md
FETCH_BYTE_QUEUE -- requirements
Module: fetch_byte_queue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: redirect_valid  in  1  load new fetch PC, flush queue.
REQ-004 SHALL have ports: redirect_addr  in  64  new PC, any byte alignment.
REQ-005 SHALL have ports: fetch_req  out  1  memory read request for one 8-byte aligned word.
REQ-006 SHALL have ports: fetch_addr  out  64  request address; bits [2:0] always 0.
REQ-007 SHALL have ports: fetch_gnt  in  1  request accepted this cycle.
REQ-008 SHALL have ports: resp_valid  in  1  read data returned.
REQ-009 SHALL have ports: resp_data  in  64  little-endian; byte k at bits [8k+7:8k].
REQ-010 SHALL have ports: buffer  out  120  [0:119] window; queue byte i at bits [i*8 +: 8]; byte 0 = oldest.
REQ-011 SHALL have ports: current_addr  out  64  address of window byte 0.
REQ-012 SHALL have ports: win_valid  out  1  occupancy >= 15.
REQ-013 SHALL have ports: consume  in  1  decoder retires byte_incr bytes.
REQ-014 SHALL have ports: byte_incr  in  4  bytes to retire, 1..15.
REQ-015 SHALL have ports: occupancy  out  6  valid bytes held, 0..32.
REQ-016 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-017 SHALL store 32 bytes in a circular array with 5-bit head/tail pointers wrapping modulo 32.
REQ-018 SHALL implement states IDLE, REQ, WAIT, DRAIN.
REQ-019 IDLE: fetch_req=0; leave only on redirect_valid -> REQ.
REQ-020 REQ: fetch_req=1, fetch_addr=fetch_ptr; only entered/held when occupancy + 8 <= 32, else hold fetch_req=0 in REQ until space frees.
REQ-021 REQ with fetch_gnt -> WAIT, fetch_ptr += 8; one outstanding request maximum.
REQ-022 WAIT with resp_valid: write bytes skip..7 of resp_data to tail in ascending order, occupancy += 8-skip, clear skip to 0, -> REQ.
REQ-023 skip SHALL equal redirect_addr[2:0] after redirect and apply only to the first response.
REQ-024 redirect_valid (any state, highest priority after reset): head=tail=0, occupancy=0, current_addr=redirect_addr, fetch_ptr={redirect_addr[63:3],3'b000}, skip=redirect_addr[2:0].
REQ-025 Redirect next state: WAIT or (REQ with fetch_gnt same cycle) -> DRAIN; otherwise -> REQ.
REQ-026 DRAIN: fetch_req=0; resp_valid discarded (no write) -> REQ; second redirect in DRAIN stays DRAIN.
REQ-027 resp_valid in IDLE or REQ SHALL be ignored.
REQ-028 consume honoured only when win_valid=1 and byte_incr != 0: head += byte_incr, current_addr += byte_incr, occupancy -= byte_incr.
REQ-029 consume with win_valid=0 or byte_incr=0 SHALL have no effect.
REQ-030 Same-cycle response write and consume: occupancy = occupancy + written - byte_incr; both pointers update.
REQ-031 buffer, current_addr, win_valid, occupancy SHALL be driven from registered state only (zero combinational path from inputs); changes visible cycle after the causing edge.
REQ-032 buffer bytes beyond occupancy SHALL be don't-care; win_valid gates use.
REQ-033 current_addr addition SHALL wrap modulo 2^64.

Reset
REQ-034 reset SHALL override all inputs including redirect_valid.
REQ-035 After reset: state IDLE, fetch_req=0, fetch_addr=0, win_valid=0, occupancy=0, current_addr=0, buffer=0, pointers=0, skip=0.
REQ-036 reset asserted in WAIT SHALL drop outstanding response context; a later resp_valid in IDLE is ignored.

Verification
REQ-037 Aligned fill: redirect 0x1000, gnt immediate, resp each word 0x0706050403020100 pattern+8n -> fetch_addr 0x1000,0x1008,0x1010,0x1018; win_valid after second response; buffer byte0=0x00, byte14=0x0E; stalls at occupancy 32.
REQ-038 Unaligned entry: redirect 0x2005 -> fetch_addr 0x2000; first resp writes 3 bytes (occupancy 3), current_addr=0x2005, byte0=resp_data[47:40].
REQ-039 Consume/wrap: fill 32, consume 15, 15 -> occupancy 2, current_addr +30; refill crosses index 31->0; window bytes contiguous and correct.
REQ-040 Simultaneous: occupancy 16 in WAIT, resp_valid and consume byte_incr=5 same cycle -> occupancy 19.
REQ-041 Redirect in WAIT: redirect 0x3000 -> DRAIN, stale resp dropped (occupancy stays 0), next fetch_addr 0x3000.
REQ-042 Reset mid-WAIT then resp_valid -> no write, occupancy 0, fetch_req 0.
